// File: rtl/ula_sequencer.sv
// ula_sequencer: issue/writeback controller feeding the combinational ALU from an 8x16 register file.
module ula_sequencer #(
  parameter int NREGS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Inst_valid,
  output logic        Inst_ready,
  input  logic [15:0] Inst_word,
  output logic [15:0] Ula_Ra,
  output logic [15:0] Ula_Rb,
  output logic [15:0] Ula_Imm,
  output logic [3:0]  Ula_sel,
  input  logic [15:0] Ula_Rd,
  output logic        Res_valid,
  input  logic        Res_ready,
  output logic [15:0] Res_data,
  output logic        Res_err
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_n;
  logic [15:0] inst_q, result_q, res_n;
  logic [15:0] regs [NREGS];
  logic err_q, exec, alu, li, rdop, wr;
  logic [3:0] op;
  logic [2:0] rd, ra, rb;
  assign op = inst_q[15:12];
  assign rd = inst_q[11:9];
  assign ra = inst_q[8:6];
  assign rb = inst_q[5:3];
  always_comb begin
    exec = state == EXEC;
    alu = op < 4'd5;
    li = op == 4'd5;
    rdop = op == 4'd6;
    Inst_ready = state == IDLE;
    Res_valid = state == RESP;
    Res_data = result_q;
    Res_err = err_q;
    Ula_Ra = exec && alu ? regs[ra] : '0;
    Ula_Rb = exec && alu ? regs[rb] : '0;
    Ula_Imm = !(exec && alu) ? '0 : op < 4'd2 ? {13'b0, inst_q[2:0]} : op == 4'd2 ? 16'hFFFF : '0;
    Ula_sel = !exec ? 4'h0 : alu ? op : 4'hF;
    res_n = alu ? Ula_Rd : li ? {7'b0, inst_q[8:0]} : rdop ? regs[ra] : '0;
    // r0 is never written, so it keeps its reset value of zero
    wr = exec && (alu || li) && rd != 3'd0;
    state_n = state == IDLE ? (Inst_valid ? EXEC : IDLE) : state == EXEC ? RESP : (Res_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      inst_q <= '0;
      result_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && Inst_valid) inst_q <= Inst_word;
      if (exec) begin
        result_q <= res_n;
        err_q <= op > 4'd6;
      end
      if (wr) regs[rd] <= res_n;
    end
  end
endmodule

// File: doc/ula_sequencer.md
# ula_sequencer

Multi-cycle issue/writeback controller that drives the processor ALU (`Ula`) from the instruction side. It accepts 16-bit instruction words over a valid/ready handshake and reads operands from an internal 8×16 register file. It presents operands, immediate and op select to the ALU, captures the ALU result, writes it back, and returns each result over a second valid/ready handshake. It sits between the instruction source and the combinational ALU, and is the only block that drives the ALU inputs.

## Interface
Parameters:
- `NREGS`, 8, register file depth. Fixed at 8 because the instruction fields are 3 bits wide.

Ports:
- `clk`, input, 1, single clock. All state is updated on the rising edge.
- `rst_n`, input, 1, active-low asynchronous reset.
- `Inst_valid`, input, 1, instruction word present.
- `Inst_ready`, output, 1, sequencer accepts an instruction this cycle.
- `Inst_word`, input, 16, instruction.
- `Ula_Ra`, output, 16, ALU operand A.
- `Ula_Rb`, output, 16, ALU operand B.
- `Ula_Imm`, output, 16, ALU immediate operand.
- `Ula_sel`, output, 4, ALU op select.
- `Ula_Rd`, input, 16, ALU result (combinational from the ALU).
- `Res_valid`, output, 1, result available.
- `Res_ready`, input, 1, consumer takes the result.
- `Res_data`, output, 16, result value.
- `Res_err`, output, 1, the instruction was illegal. Qualified by `Res_valid`.

## Operation
Instruction format:
- `[15:12]` op, `[11:9]` rd, `[8:6]` ra, `[5:3]` rb, `[2:0]` imm3.

Op decode:
- 0 ADD: sel 0000, Imm = zero-extended imm3.
- 1 SUB: sel 0001, Imm = zero-extended imm3.
- 2 AND: sel 0010, Imm = 16'hFFFF.
- 3 OR: sel 0011, Imm = 16'h0000.
- 4 XOR: sel 0100, Imm = 16'h0000.
- 5 LI: rd <= zero-extended `[8:0]`. The ALU is not used.
- 6 RD: result = reg[ra]. No register is written.
- 7–15: illegal. No register is written; `Res_err`=1 and `Res_data`=0.

Register file:
- r0 reads as 0 and writes to it are discarded.
- Reads are combinational; the single write port is active only in EXEC.

State machine (IDLE, EXEC, RESP):
- IDLE: `Inst_ready`=1. When `Inst_valid` is high, latch `Inst_word` and go to EXEC.
- EXEC (exactly 1 cycle): `Ula_Ra`=reg[ra], `Ula_Rb`=reg[rb], Imm/sel per the decode table. For non-ALU ops: sel=1111 and Ra=Rb=Imm=0.
  - At the clock edge, load `result_q` with `Ula_Rd` (ALU ops), the immediate (LI), reg[ra] (RD), or 0 (illegal).
  - At the same edge, write rd for ALU ops and LI, then go to RESP.
- RESP: `Res_valid`=1. `Res_data`/`Res_err` come from registers and are stable. When `Res_ready` is high, go to IDLE.

ALU drive and arithmetic:
- Outside EXEC, all `Ula_*` outputs are 0.
- Arithmetic is modulo 2^16. Wrap-around is not flagged. Example: SUB 0-0-1 gives 16'hFFFF.

Boundary cases:
- `Inst_ready`=0 in EXEC and RESP. `Inst_valid` in those states is ignored; the word is not lost, because the producer must hold it until it sees ready.
- rd==ra or rd==rb: operands use the pre-write value, since the write happens at the end of EXEC.
- Reset (async, any state): clear state to IDLE, all registers to 0, `result_q`/`Res_err` to 0. An instruction in flight is aborted with no writeback.

Reset values of outputs:
- `Inst_ready`=1.
- `Res_valid`=0, `Res_data`=0, `Res_err`=0.
- `Ula_Ra`/`Ula_Rb`/`Ula_Imm`=0, `Ula_sel`=0.

## Timing
- Accept edge is T0. EXEC occupies cycle T0→T1. `Res_valid` rises after T1.
- Minimum cost is 3 cycles per instruction when `Res_ready` is held at 1.
- The register write is visible to an instruction accepted after the RESP handshake completes.
- `Inst_ready` and `Res_valid` are decoded from the registered state only, with no combinational path from `Inst_valid` or `Res_ready`.
- The ALU path is purely combinational within the EXEC cycle. `Ula_Rd` must settle within one clock.

## Test plan
- LI r1,5 (0x5205), `Res_ready`=1:
  - `Res_valid` high 2 cycles after accept, with `Res_data`=0x0005 and `Res_err`=0.
  - `Inst_ready` returns high 1 cycle later.
- LI r2,3, then ADD r3,r1,r2,#1 (0x0651):
  - In EXEC, the ALU stub sees Ra=5, Rb=3, Imm=1, sel=0000.
  - `Res_data`=9. A following RD r3 (0x60C0) returns 9.
- LI r0,7 (0x5007) returns `Res_data`=7. A following RD r0 (0x6000) returns 0.
- Illegal op 0xF000:
  - `Res_err`=1 and `Res_data`=0.
  - In EXEC, sel=1111. RD of r1..r7 shows no change.
- Back-pressure: hold `Res_ready`=0 for 5 cycles.
  - `Res_valid` stays 1 and `Res_data` stays stable; `Inst_ready` stays 0.
  - A second word held on `Inst_valid` is accepted only after the handshake, and is processed exactly once.
- Assert `rst_n` low during EXEC of ADD r3 (r3 previously 9):
  - Outputs return to their reset values immediately.
  - After release, RD r3 returns 0, and no spurious `Res_valid` occurs.
